// File: rtl/signmag_minmax_if.sv
// Handshake bundle for signmag_minmax: frame control, sample stream and result port.
interface signmag_minmax_if #(
    parameter int DATA_W = 7,
    parameter int LEN_W  = 4
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_min;
    logic [DATA_W-1:0] out_max;
    logic              out_ready;
    logic              busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_min, out_max, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_min, out_max, busy
    );
endinterface

// File: rtl/signmag_minmax.sv
// Running min/max over a frame of sign-magnitude samples, held until the consumer takes it.
module signmag_minmax #(
    parameter int DATA_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    signmag_minmax_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

    state_t            state, state_next;
    logic [4:0]        cnt_p0;
    logic [4:0]        len_p0;
    logic [DATA_W-1:0] min_p0;
    logic [DATA_W-1:0] max_p0;
    logic [DATA_W-1:0] sample;
    logic              xfer;
    logic              last;

    // -0 folds onto +0 so it can never reach the result registers.
    function automatic logic [DATA_W-1:0] normalise(input logic [DATA_W-1:0] x);
        return (x[DATA_W-2:0] == '0) ? '0 : x;
    endfunction

    function automatic logic signed [DATA_W-1:0] sm_value(input logic [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] mag;
        mag = signed'({1'b0, x[DATA_W-2:0]});
        return x[DATA_W-1] ? -mag : mag;
    endfunction

    assign sample = normalise(bus.in_data);
    assign xfer   = (state == ACCUM) && bus.in_valid;
    assign last   = ((cnt_p0 + 5'd1) == len_p0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start)     state_next = ACCUM;
            ACCUM:   if (xfer && last)  state_next = HOLD;
            HOLD:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ACCUM);
        bus.out_valid = (state == HOLD);
        bus.busy      = (state != IDLE);
    end

    // Stage p0: frame length, sample count and running extremes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
            len_p0 <= '0;
            min_p0 <= '0;
            max_p0 <= '0;
        end else if ((state == IDLE) && bus.start) begin
            cnt_p0 <= '0;
            len_p0 <= (bus.len == 4'd0) ? 5'd16 : {1'b0, bus.len};
        end else if (xfer) begin
            cnt_p0 <= cnt_p0 + 5'd1;
            if (cnt_p0 == 5'd0) begin
                min_p0 <= sample;
                max_p0 <= sample;
            end else begin
                if (sm_value(sample) < sm_value(min_p0)) min_p0 <= sample;
                if (sm_value(sample) > sm_value(max_p0)) max_p0 <= sample;
            end
        end
    end

    assign bus.out_min = min_p0;
    assign bus.out_max = max_p0;
endmodule

// File: tb/tb_signmag_minmax.sv
// Scoreboard bench: frame drivers push expected min/max, a monitor pops on each result handshake.
module tb_signmag_minmax;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rdy_mode = 0;
    bit   gaps_on  = 0;
    logic [6:0]  smp [16];
    logic [13:0] exp_q [$];

    signmag_minmax_if bus ();

    signmag_minmax dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: results are checked only when the handshake actually completes.
    initial begin
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                chk("no_minus_zero_min", 16'(bus.out_min == 7'h40), 16'd0);
                chk("no_minus_zero_max", 16'(bus.out_max == 7'h40), 16'd0);
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 16'(1), 16'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_min", 16'(bus.out_min), 16'(e[13:7]));
                        chk("out_max", 16'(bus.out_max), 16'(e[6:0]));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_sample(input logic [6:0] s);
        bit ok;
        int g;
        if (gaps_on) begin
            g = $urandom_range(0, 2);
            repeat (g) begin @(posedge clk); #1; end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = s;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        chk("in_ready_wait", 16'(ok), 16'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 7'h2A;
    endtask

    task automatic start_frame(input logic [3:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.len   = 4'd9;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = !bus.busy;
        end
        chk("return_to_idle", 16'(ok), 16'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [3:0] l, input int n,
                             input logic [6:0] emin, input logic [6:0] emax);
        exp_q.push_back({emin, emax});
        start_frame(l);
        for (int i = 0; i < n; i++) send_sample(smp[i]);
        @(negedge clk);
        chk("latency_out_valid", 16'(bus.out_valid), 16'd1);
        chk("hold_in_ready", 16'(bus.in_ready), 16'd0);
        wait_idle();
    endtask

    function automatic int sm_int(input logic [6:0] x);
        return x[6] ? -int'(x[5:0]) : int'(x[5:0]);
    endfunction

    function automatic logic [6:0] int_sm(input int v);
        return (v < 0) ? {1'b1, 6'(-v)} : {1'b0, 6'(v)};
    endfunction

    initial begin
        int lo, hi, n;
        logic [3:0] l;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 7'h00;
        bus.out_ready = 1'b1;
        #2;
        chk("reset_busy", 16'(bus.busy), 16'd0);
        chk("reset_in_ready", 16'(bus.in_ready), 16'd0);
        chk("reset_out_valid", 16'(bus.out_valid), 16'd0);
        chk("reset_min_max", 16'({bus.out_min, bus.out_max}), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // in_valid in IDLE must not be consumed
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 16'(bus.in_ready), 16'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        smp[0] = 7'h05; smp[1] = 7'h43; smp[2] = 7'h14; smp[3] = 7'h40;
        run_frame(4'd4, 4, 7'h43, 7'h14);

        for (int i = 0; i < 16; i++) smp[i] = (i % 2 == 0) ? 7'h7F : 7'h3F;
        run_frame(4'd0, 16, 7'h7F, 7'h3F);

        smp[0] = 7'h40; smp[1] = 7'h00;
        run_frame(4'd2, 2, 7'h00, 7'h00);

        smp[0] = 7'h40; smp[1] = 7'h01; smp[2] = 7'h41;
        run_frame(4'd3, 3, 7'h41, 7'h01);

        smp[0] = 7'h40; smp[1] = 7'h41; smp[2] = 7'h7F;
        run_frame(4'd3, 3, 7'h7F, 7'h00);

        smp[0] = 7'h3F;
        run_frame(4'd1, 1, 7'h3F, 7'h3F);

        // Result held with out_ready low while in_valid and start are pushed at it
        bus.out_ready = 1'b0;
        exp_q.push_back({7'h42, 7'h03});
        start_frame(4'd3);
        smp[0] = 7'h01; smp[1] = 7'h42; smp[2] = 7'h03;
        for (int i = 0; i < 3; i++) send_sample(smp[i]);
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h7F;
        for (int c = 0; c < 10; c++) begin
            bus.start = (c == 4);
            @(negedge clk);
            chk("hold_stable_min", 16'(bus.out_min), 16'h42);
            chk("hold_stable_max", 16'(bus.out_max), 16'h03);
            chk("hold_in_ready_low", 16'(bus.in_ready), 16'd0);
            chk("hold_state", 16'({bus.busy, bus.out_valid}), 16'b11);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len       = 4'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("hold_exit_idle", 16'({bus.busy, bus.out_valid}), 16'b00);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("start_at_exit_ignored", 16'(bus.busy), 16'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a len = 8 frame
        start_frame(4'd8);
        smp[0] = 7'h10; smp[1] = 7'h50; smp[2] = 7'h22;
        for (int i = 0; i < 3; i++) send_sample(smp[i]);
        rst_n = 1'b0;
        #1;
        chk("midreset_flags", 16'({bus.busy, bus.in_ready, bus.out_valid}), 16'd0);
        chk("midreset_min_max", 16'({bus.out_min, bus.out_max}), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_reset_no_valid", 16'(bus.out_valid), 16'd0);
        end
        @(posedge clk);
        #1;
        smp[0] = 7'h47;
        run_frame(4'd1, 1, 7'h47, 7'h47);

        // Random frames against an integer-domain reference
        gaps_on  = 1;
        rdy_mode = 1;
        for (int f = 0; f < 8; f++) begin
            l  = 4'($urandom_range(0, 15));
            n  = (l == 0) ? 16 : int'(l);
            lo = 1000;
            hi = -1000;
            for (int i = 0; i < n; i++) begin
                smp[i] = 7'($urandom_range(0, 127));
                if (sm_int(smp[i]) < lo) lo = sm_int(smp[i]);
                if (sm_int(smp[i]) > hi) hi = sm_int(smp[i]);
            end
            run_frame(l, n, int_sm(lo), int_sm(hi));
        end
        rdy_mode      = 0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
